// File: rtl/rob_retire_pkg.sv
// Shared types and constants for the reorder buffer retire path.
package rob_retire_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int RobSize   = ROB_DEPTH;
  localparam int ROB_TAG_W = $clog2(RobSize + 1);

  // Tag value meaning "no entry"; live tags run 1..ROB_DEPTH.
  localparam logic [ROB_TAG_W-1:0] TAG_NONE = '0;

  typedef logic [31:0] MemoryWord;

  typedef struct packed {
    logic regwr;
    logic flush;
  } control_bits;

  typedef struct packed {
    logic [4:0]           rd;
    logic [ROB_TAG_W-1:0] tag;
  } map_table_entry;

  typedef struct packed {
    logic        ready;
    control_bits ctrl_bits;
    logic [4:0]  rd;
    MemoryWord   value;
  } rob_entry;

  // Register x0 is hardwired, so a write to it never reaches the register file.
  function automatic logic writes_rf(rob_entry e);
    return e.ctrl_bits.regwr && (e.rd != 5'd0);
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the ROB ring; flush rewinds everything to slot 0.
module rob_ptr_ctrl #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int TAG_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_fire,
  input  logic             retire_fire,
  input  logic             flush_fire,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W-1:0] tail,
  output logic [TAG_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
  localparam logic [TAG_W-1:0] DEPTH_T = TAG_W'(DEPTH);

  assign full  = (count == DEPTH_T);
  assign empty = (count == '0);

  // Advance pointers with wrap and track occupancy; flush outranks alloc/retire.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_fire) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire)  tail <= (tail == LAST) ? '0 : tail + IDX_W'(1);
      if (retire_fire) head <= (head == LAST) ? '0 : head + IDX_W'(1);
      if (alloc_fire && !retire_fire)      count <= count + TAG_W'(1);
      else if (!alloc_fire && retire_fire) count <= count - TAG_W'(1);
    end
  end

endmodule

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocates at dispatch, absorbs commit updates, retires the head.
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  rob_entry         alloc_entry,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic [TAG_W-1:0] wb_tag,
  input  rob_entry         wb_entry,
  output logic             retire_valid,
  output logic [TAG_W-1:0] retire_tag,
  output logic [4:0]       retire_rd,
  output MemoryWord        retire_value,
  output logic             retire_regwr,
  output logic             flush,
  output logic [TAG_W-1:0] count
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] DEPTH_T = TAG_W'(DEPTH);

  rob_entry         entries [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic             full;
  logic             empty;

  rob_entry         head_entry;
  rob_entry         alloc_clean;
  logic             retire_go;
  logic             flush_go;
  logic             alloc_fire;
  logic             wb_hit;
  logic [IDX_W-1:0] wb_idx;

  assign head_entry  = entries[head];
  assign alloc_ready = !full;
  assign alloc_tag   = TAG_W'(tail) + TAG_W'(1);
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Retire decision looks only at registered state, so a fresh writeback waits one cycle.
  assign retire_go = !empty && busy[head] && head_entry.ready;
  assign flush_go  = retire_go && head_entry.ctrl_bits.flush;

  // Stale tags (retired, flushed, or never issued) must not disturb live entries.
  assign wb_idx = IDX_W'(wb_tag - TAG_W'(1));
  assign wb_hit = (wb_tag != TAG_W'(TAG_NONE)) && (wb_tag <= DEPTH_T) && busy[wb_idx];

  // New entries always start not-ready regardless of what dispatch supplies.
  always_comb begin
    alloc_clean       = alloc_entry;
    alloc_clean.ready = 1'b0;
  end

  rob_ptr_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_ptr (
    .clk         (clk),
    .reset       (reset),
    .alloc_fire  (alloc_fire),
    .retire_fire (retire_go),
    .flush_fire  (flush_go),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // Entry payload storage; validity is carried by busy, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (!flush_go) begin
      if (alloc_fire) entries[tail]   <= alloc_clean;
      if (wb_hit)     entries[wb_idx] <= wb_entry;
    end
  end

  // Busy bits: set on alloc, cleared on retire, wiped on flush or reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= '0;
    end else if (flush_go) begin
      busy <= '0;
    end else begin
      if (alloc_fire) busy[tail] <= 1'b1;
      if (retire_go)  busy[head] <= 1'b0;
    end
  end

  // Registered retire/flush outputs: one-cycle pulse carrying the retired entry, zero otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_valid <= 1'b0;
      retire_tag   <= '0;
      retire_rd    <= '0;
      retire_value <= '0;
      retire_regwr <= 1'b0;
      flush        <= 1'b0;
    end else begin
      retire_valid <= retire_go;
      flush        <= flush_go;
      if (retire_go) begin
        retire_tag   <= TAG_W'(head) + TAG_W'(1);
        retire_rd    <= head_entry.rd;
        retire_value <= head_entry.value;
        retire_regwr <= writes_rf(head_entry);
      end else begin
        retire_tag   <= '0;
        retire_rd    <= '0;
        retire_value <= '0;
        retire_regwr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: vector table plus hand sequences, retire scoreboard.
module tb_rob_retire;
  import rob_retire_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alloc_valid = 1'b0;
  rob_entry    alloc_entry = '0;
  logic        alloc_ready;
  logic [4:0]  alloc_tag;
  logic [4:0]  wb_tag = '0;
  rob_entry    wb_entry = '0;
  logic        retire_valid;
  logic [4:0]  retire_tag;
  logic [4:0]  retire_rd;
  MemoryWord   retire_value;
  logic        retire_regwr;
  logic        flush;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int tag; int rd; int val; int rw; int fl;
  } exp_t;
  exp_t exp_q[$];

  // cnt/tag: expected count and alloc_tag before the edge (cnt<0 skips)
  // av/ard: alloc request; wt/wrd/wval/wrw/wfl: writeback (ready=1, wt=0 still drives)
  // push..pfl: retire expected later, queued when this row is driven
  typedef struct {
    int cnt; int tag;
    int av; int ard;
    int wt; int wrd; int wval; int wrw; int wfl;
    int push; int ptag; int prd; int pval; int prw; int pfl;
  } vec_t;
  vec_t vecs[23];

  rob_retire dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_entry  (alloc_entry),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .wb_tag       (wb_tag),
    .wb_entry     (wb_entry),
    .retire_valid (retire_valid),
    .retire_tag   (retire_tag),
    .retire_rd    (retire_rd),
    .retire_value (retire_value),
    .retire_regwr (retire_regwr),
    .flush        (flush),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alloc(input int av, input int rd);
    alloc_valid                 = (av != 0);
    alloc_entry.ready           = 1'b1;
    alloc_entry.ctrl_bits.regwr = 1'b1;
    alloc_entry.ctrl_bits.flush = 1'b0;
    alloc_entry.rd              = 5'(rd);
    alloc_entry.value           = 32'hDEAD0000 | 32'(rd);
  endtask

  task automatic drive_wb(input int wt, input int rd, input int val, input int rw, input int fl);
    wb_tag                   = 5'(wt);
    wb_entry.ready           = 1'b1;
    wb_entry.ctrl_bits.regwr = (rw != 0);
    wb_entry.ctrl_bits.flush = (fl != 0);
    wb_entry.rd              = 5'(rd);
    wb_entry.value           = 32'(val);
  endtask

  task automatic drive_idle();
    drive_alloc(0, 0);
    drive_wb(0, 0, 0, 0, 0);
  endtask

  task automatic push_exp(input int tag, input int rd, input int val, input int rw, input int fl);
    exp_t e;
    e.tag = tag; e.rd = rd; e.val = val; e.rw = rw; e.fl = fl;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Retire monitor: each retire pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (retire_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", {retire_tag, retire_rd}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("retire", {retire_tag, retire_rd, retire_value, retire_regwr, flush},
                {5'(e.tag), 5'(e.rd), 32'(e.val), 1'(e.rw), 1'(e.fl)});
        end
      end else begin
        check("idle_outputs", {retire_tag, retire_rd, retire_value, retire_regwr, flush}, 64'd0);
      end
    end
  end

  initial begin
    vecs = '{
      '{0,1, 1,5,  0,0,0,0,0,         0,0,0,0,0,0},
      '{1,2, 1,6,  0,0,0,0,0,         0,0,0,0,0,0},
      '{2,3, 1,7,  0,0,0,0,0,         0,0,0,0,0,0},
      '{3,4, 0,0,  2,6,'hAA,1,0,      0,0,0,0,0,0},
      '{3,4, 0,0,  1,5,'h11,1,0,      1,1,5,'h11,1,0},
      '{3,4, 0,0,  0,0,0,0,0,         1,2,6,'hAA,1,0},
      '{2,4, 0,0,  0,0,0,0,0,         0,0,0,0,0,0},
      '{1,4, 0,0,  0,3,'h33,1,0,      0,0,0,0,0,0},
      '{1,4, 0,0,  20,3,'h34,1,0,     0,0,0,0,0,0},
      '{1,4, 0,0,  9,3,'h35,1,0,      0,0,0,0,0,0},
      '{1,4, 0,0,  1,3,'h36,1,0,      0,0,0,0,0,0},
      '{1,4, 0,0,  3,7,'h77,1,0,      1,3,7,'h77,1,0},
      '{1,4, 0,0,  0,0,0,0,0,         0,0,0,0,0,0},
      '{0,4, 1,8,  0,0,0,0,0,         0,0,0,0,0,0},
      '{1,5, 1,9,  0,0,0,0,0,         0,0,0,0,0,0},
      '{2,6, 1,10, 0,0,0,0,0,         0,0,0,0,0,0},
      '{3,7, 0,0,  4,8,'h44,0,1,      1,4,8,'h44,0,1},
      '{3,7, 1,11, 5,9,'h55,1,0,      0,0,0,0,0,0},
      '{0,1, 0,0,  5,9,'h56,1,0,      0,0,0,0,0,0},
      '{0,1, 1,0,  0,0,0,0,0,         0,0,0,0,0,0},
      '{1,2, 0,0,  1,0,'h99,1,0,      1,1,0,'h99,0,0},
      '{1,2, 0,0,  0,0,0,0,0,         0,0,0,0,0,0},
      '{0,2, 0,0,  0,0,0,0,0,         0,0,0,0,0,0}
    };

    apply_reset();
    check("reset_count", count, 0);
    check("reset_alloc_ready", alloc_ready, 1);
    check("reset_alloc_tag", alloc_tag, 1);
    check("reset_retire_valid", retire_valid, 0);
    check("reset_flush", flush, 0);

    for (int i = 0; i < 23; i++) begin
      if (vecs[i].cnt >= 0) begin
        check($sformatf("v%0d_count", i), count, 64'(vecs[i].cnt));
        check($sformatf("v%0d_alloc_tag", i), alloc_tag, 64'(vecs[i].tag));
        check($sformatf("v%0d_alloc_ready", i), alloc_ready, 1);
      end
      drive_alloc(vecs[i].av, vecs[i].ard);
      drive_wb(vecs[i].wt, vecs[i].wrd, vecs[i].wval, vecs[i].wrw, vecs[i].wfl);
      if (vecs[i].push != 0)
        push_exp(vecs[i].ptag, vecs[i].prd, vecs[i].pval, vecs[i].prw, vecs[i].pfl);
      tick();
    end
    drive_idle();

    // Fill to capacity, hold an alloc across a retire, and see the tail wrap to tag 1.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_tag%0d", i), alloc_tag, 64'(i + 1));
      drive_alloc(1, i + 1);
      tick();
    end
    check("full_count", count, 16);
    check("full_alloc_ready", alloc_ready, 0);
    tick();
    check("full_hold_count", count, 16);
    drive_wb(1, 1, 'h1001, 1, 0);
    push_exp(1, 1, 'h1001, 1, 0);
    tick();
    drive_wb(0, 0, 0, 0, 0);
    check("full_before_retire", alloc_ready, 0);
    tick();
    check("after_retire_count", count, 15);
    check("after_retire_ready", alloc_ready, 1);
    check("wrap_tag", alloc_tag, 1);
    tick();
    drive_idle();
    check("refill_count", count, 16);
    check("refill_ready", alloc_ready, 0);

    // Reset while the head is retirable: no retire or flush pulse may escape.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(1, i + 20);
      tick();
    end
    drive_idle();
    check("pre_reset_count", count, 5);
    drive_wb(1, 3, 'h2002, 1, 1);
    tick();
    drive_idle();
    reset = 1'b0;
    tick();
    check("midreset_retire_valid", retire_valid, 0);
    check("midreset_flush", flush, 0);
    reset = 1'b1;
    check("post_reset_count", count, 0);
    check("post_reset_ready", alloc_ready, 1);
    check("post_reset_tag", alloc_tag, 1);
    tick();
    tick();
    check("post_reset_count2", count, 0);
    check("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order reorder buffer that sits directly downstream of the commit/writeback stage.
- Allocates tagged entries at dispatch and absorbs the updated rob_entry that commit produces for a tag.
- Retires the head entry in program order once it is ready, driving register-file write and map-table release.
- Raises a pipeline flush when a retiring entry carries ctrl_bits.flush (branch mispredict).

Parameters:
DEPTH, 16, number of ROB entries; tags run 1..DEPTH, tag 0 means "no entry"
TAG_W, $clog2(DEPTH+1), width of a tag (matches RobSize)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset: state clears on a rising clk edge while reset==0
alloc_valid  input  1  dispatch requests a new entry this cycle
alloc_entry  input  rob_entry  initial entry contents (ready forced to 0 on write)
alloc_ready  output  1  space available; alloc accepted only when alloc_valid && alloc_ready
alloc_tag  output  TAG_W  tag assigned to an accepted allocation (tail index + 1)
wb_tag  input  TAG_W  tag of the entry commit updated; 0 = no update
wb_entry  input  rob_entry  replacement entry contents from commit (re1)
retire_valid  output  1  one-cycle pulse: an entry retired
retire_tag  output  TAG_W  tag of the retired entry
retire_rd  output  5  destination register of the retired entry
retire_value  output  MemoryWord  result value of the retired entry
retire_regwr  output  1  retired entry writes the register file (ctrl_bits.regwr && rd!=0)
flush  output  1  one-cycle pulse: mispredict retired, younger state discarded
count  output  TAG_W  occupied entries

Behaviour:
- State: entry array [DEPTH] of rob_entry plus busy bit each; head, tail pointers (0..DEPTH-1); count.
- Reset (reset==0 at edge): head=tail=count=0, all busy=0. Outputs: alloc_ready=1, alloc_tag=1, retire_* = 0, flush=0, count=0.
- alloc_ready = (count < DEPTH), computed from registered count only; no credit from a same-cycle retire.
- alloc_tag = tail+1, combinational.
- Accepted alloc: entry[tail]=alloc_entry with ready=0; busy[tail]=1; tail wraps DEPTH-1 -> 0.
- Writeback: if wb_tag in 1..DEPTH and busy[wb_tag-1], overwrite entry[wb_tag-1] with wb_entry. Otherwise ignore: tag 0, out-of-range, or not-busy entries (stale, post-flush).
- Retire eligibility: count>0 && busy[head] && entry[head].ready, evaluated on registered state. Consequences:
  - a writeback to the head becomes retirable one cycle after it is written; no bypass.
  - latency from wb to retire_valid is at least 1 cycle.
- Retire action at edge: busy[head]=0, head++ (wraps). retire_* outputs registered: they hold the retired entry's fields for exactly one cycle, then return to 0.
- At most one retire per cycle.
- count update: +1 on accepted alloc, -1 on retire; both in the same cycle = unchanged.
- Mispredict: if the retiring entry has ctrl_bits.flush=1, then on that same edge:
  - retire_valid=1 with the entry's fields, and flush=1 for one cycle.
  - all busy cleared; head=tail=0; count=0.
  - any alloc in that cycle is discarded (alloc_ready still showed 1; dispatch drops it on flush).
  - any wb in that cycle is discarded.
- Flush cycle (flush==1): alloc_ready=1, alloc_tag=1. Normal operation resumes the next cycle.
- Full (count==DEPTH): alloc_ready=0; a retire that cycle frees space visible next cycle.
- Empty: no retire; writebacks ignored because no entry is busy.
- Reset mid-operation overrides all activity that cycle: no retire or flush pulse is emitted.

Decomposition:
- Shared package: rob_entry, map_table_entry, control_bits, RobSize, MemoryWord (existing); add ROB_DEPTH constant and a TAG_NONE=0 constant.
- One natural sub-module: rob_ptr_ctrl, holding head/tail/count with wrap and full/empty logic, instantiated once.
- Entry storage and retire/flush logic live in rob_retire.

Test Plan:
- Reset then alloc 3 entries (rd=5,6,7) -> alloc_tag 1,2,3; count=3; no retire_valid.
- wb_tag=2 ready, value 0xAA -> no retire (head 1 not ready). Then wb_tag=1 value 0x11 -> retire tag1 (rd5, 0x11) one cycle later, then tag2 (rd6, 0xAA) next cycle; count=1.
- Fill 16 entries -> alloc_ready=0 at count=16. Alloc held during a retire -> accepted only the following cycle. Tail wraps: 17th tag issued is 1.
- Entry tag4 ready with ctrl_bits.flush=1, tags 5-6 busy, alloc_valid same cycle -> retire tag4 plus flush pulse. Next cycle count=0, alloc_tag=1. wb_tag=5 afterwards ignored.
- wb_tag=0, wb_tag=20, and wb to a non-busy tag -> no state change, count unchanged.
- Assert reset (0) while count=5 and head ready -> no retire_valid, no flush. Next cycle count=0, alloc_ready=1.
